// File: rtl/can_tx_scheduler.sv
// ---------------------------------------------------------------------------
// can_tx_scheduler
//
// Sits between a priority-ordered transmit buffer and a bit-level CAN
// transmitter. It holds off for an inter-frame gap, samples the buffer head
// only at the moment of launch, and then keeps that frame stable on mac_* until
// the transmitter reports done, arbitration lost or error. It handles retries
// and drops, and pops the buffer head when a frame leaves the scheduler.
//
// Parameters
//   MAX_RETRY   error retries allowed per frame before it is dropped
//   IFS_CYCLES  idle clocks before every frame launch (1..255)
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   en                        scheduler enable (level)
//   buf_valid, buf_id,        buffer head: valid, 11-bit id, dlc, 8 data bytes
//   buf_dlc, buf_data
//   buf_re                    one-cycle pop of the buffer head
//   mac_tx_req                one-cycle launch pulse to the transmitter
//   mac_id, mac_dlc, mac_data latched frame, stable from launch to completion
//   mac_tx_done, mac_arb_lost,
//   mac_tx_err                transmitter completion pulses
//   tx_ok, tx_drop            one-cycle result pulses
//   retry_cnt                 error retries consumed by the head frame
//   busy                      high whenever the FSM is not IDLE
//   state_dbg                 current FSM state (IDLE=0, GAP=1, ACTIVE=2)
//
// Handshake: every *_req / *_re / completion signal is a single-cycle pulse
// sampled on the rising clock edge; there is no back-pressure, so a pulse is
// consumed in the cycle it is seen (or ignored when the FSM is not ACTIVE).
// ---------------------------------------------------------------------------
module can_tx_scheduler #(
  parameter int MAX_RETRY  = 3,
  parameter int IFS_CYCLES = 3,
  // A zero-width counter is not legal, so MAX_RETRY=0 keeps one bit.
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          buf_valid,
  input  logic [10:0]   buf_id,
  input  logic [3:0]    buf_dlc,
  input  logic [7:0]    buf_data [0:7],
  output logic          buf_re,
  output logic          mac_tx_req,
  output logic [10:0]   mac_id,
  output logic [3:0]    mac_dlc,
  output logic [7:0]    mac_data [0:7],
  input  logic          mac_tx_done,
  input  logic          mac_arb_lost,
  input  logic          mac_tx_err,
  output logic          tx_ok,
  output logic          tx_drop,
  output logic [RW-1:0] retry_cnt,
  output logic          busy,
  output logic [1:0]    state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GAP    = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  localparam logic [7:0]    IFS_M1 = 8'(IFS_CYCLES - 1);
  localparam logic [RW-1:0] MAX_R  = RW'(MAX_RETRY);

  state_t        state_q, state_d;
  logic [7:0]    gap_q, gap_d;
  logic [10:0]   mac_id_q, mac_id_d;
  logic [3:0]    mac_dlc_q, mac_dlc_d;
  logic [7:0]    mac_data_q [0:7];
  logic [7:0]    mac_data_d [0:7];
  logic [10:0]   last_id_q, last_id_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          tx_req_q, tx_req_d;
  logic          buf_re_q, buf_re_d;
  logic          tx_ok_q, tx_ok_d;
  logic          tx_drop_q, tx_drop_d;

  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    mac_id_d  = mac_id_q;
    mac_dlc_d = mac_dlc_q;
    for (int i = 0; i < 8; i++) mac_data_d[i] = mac_data_q[i];
    last_id_d = last_id_q;
    retry_d   = retry_q;
    tx_req_d  = 1'b0;
    buf_re_d  = 1'b0;
    tx_ok_d   = 1'b0;
    tx_drop_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (en && buf_valid) begin
          gap_d   = IFS_M1;
          state_d = GAP;
        end
      end

      GAP: begin
        if (gap_q != 8'd0) begin
          gap_d = gap_q - 8'd1;
        end else if (en && buf_valid) begin
          // The head is sampled here and only here, so anything that
          // preempted the buffer during the gap is what goes out.
          mac_id_d  = buf_id;
          mac_dlc_d = buf_dlc;
          for (int i = 0; i < 8; i++) mac_data_d[i] = buf_data[i];
          last_id_d = buf_id;
          // A new id at the head means a new frame: its retry budget is fresh.
          if (buf_id != last_id_q) retry_d = '0;
          tx_req_d  = 1'b1;
          state_d   = ACTIVE;
        end else begin
          state_d = IDLE;
        end
      end

      ACTIVE: begin
        // Priority: done > err > arb_lost; exactly one action per cycle.
        if (mac_tx_done) begin
          buf_re_d = 1'b1;
          tx_ok_d  = 1'b1;
          retry_d  = '0;
          gap_d    = IFS_M1;
          state_d  = GAP;
        end else if (mac_tx_err) begin
          if (retry_q == MAX_R) begin
            buf_re_d  = 1'b1;
            tx_drop_d = 1'b1;
            retry_d   = '0;
          end else begin
            retry_d = retry_q + RW'(1);
          end
          gap_d   = IFS_M1;
          state_d = GAP;
        end else if (mac_arb_lost) begin
          gap_d   = IFS_M1;
          state_d = GAP;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gap_q     <= '0;
      mac_id_q  <= '0;
      mac_dlc_q <= '0;
      for (int i = 0; i < 8; i++) mac_data_q[i] <= '0;
      last_id_q <= '0;
      retry_q   <= '0;
      tx_req_q  <= 1'b0;
      buf_re_q  <= 1'b0;
      tx_ok_q   <= 1'b0;
      tx_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gap_q     <= gap_d;
      mac_id_q  <= mac_id_d;
      mac_dlc_q <= mac_dlc_d;
      for (int i = 0; i < 8; i++) mac_data_q[i] <= mac_data_d[i];
      last_id_q <= last_id_d;
      retry_q   <= retry_d;
      tx_req_q  <= tx_req_d;
      buf_re_q  <= buf_re_d;
      tx_ok_q   <= tx_ok_d;
      tx_drop_q <= tx_drop_d;
    end
  end

  // The pop is registered, so gate it with the live valid: a head that
  // vanished in the meantime must never be popped.
  assign buf_re     = buf_re_q & buf_valid;
  assign mac_tx_req = tx_req_q;
  assign mac_id     = mac_id_q;
  assign mac_dlc    = mac_dlc_q;
  assign mac_data   = mac_data_q;
  assign tx_ok      = tx_ok_q;
  assign tx_drop    = tx_drop_q;
  assign retry_cnt  = retry_q;
  assign busy       = (state_q != IDLE);
  assign state_dbg  = state_q;

endmodule
